// File: rtl/fpnew_pkg.sv
// Slice of the shared FPU package: items used by the iterative divsqrt mantissa unit.
package fpnew_pkg;

  typedef enum logic [1:0] {
    DIVSQRT_IDLE,
    DIVSQRT_BUSY,
    DIVSQRT_DONE
  } divsqrt_iter_state_e;

  // integer bit + (mant_width-1) fraction bits + guard + round
  function automatic int unsigned divsqrt_num_iter(input int unsigned mant_width);
    return mant_width + 2;
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_mant_step.sv
// One restoring radix-2 step shared by division and square root.
module fpnew_divsqrt_mant_step #(
  parameter int unsigned REM_WIDTH = 57
) (
  input  logic [REM_WIDTH-1:0] rem_i,
  input  logic [1:0]           rad_bits_i,
  input  logic [REM_WIDTH-1:0] trial_i,
  input  logic                 is_sqrt_i,
  output logic [REM_WIDTH-1:0] rem_o,
  output logic                 bit_o
);

  logic [REM_WIDTH-1:0] part;
  logic [REM_WIDTH:0]   diff;
  logic [REM_WIDTH-1:0] sel;

  always_comb begin
    // sqrt brings in the next radicand pair before the compare; div shifts after it
    part  = is_sqrt_i ? {rem_i[REM_WIDTH-3:0], rad_bits_i} : rem_i;
    diff  = {1'b0, part} - {1'b0, trial_i};
    bit_o = ~diff[REM_WIDTH];
    sel   = bit_o ? diff[REM_WIDTH-1:0] : part;
    rem_o = is_sqrt_i ? sel : {sel[REM_WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/fpnew_divsqrt_mant_iter.sv
// Iterative radix-2 div/sqrt mantissa core, one result bit per cycle, start/kill/ready/done handshake.
module fpnew_divsqrt_mant_iter
  import fpnew_pkg::*;
#(
  parameter  int unsigned MANT_WIDTH = 53,
  localparam int unsigned NUM_ITER   = divsqrt_num_iter(MANT_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  div_start_i,
  input  logic                  sqrt_start_i,
  input  logic                  kill_i,
  input  logic [MANT_WIDTH-1:0] mant_a_i,
  input  logic [MANT_WIDTH-1:0] mant_b_i,
  input  logic                  sqrt_odd_exp_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [NUM_ITER-1:0]   result_o,
  output logic                  sticky_o
);

  localparam int unsigned REM_W = NUM_ITER + 2;
  localparam int unsigned RAD_W = 2 * NUM_ITER;
  localparam int unsigned CNT_W = $clog2(NUM_ITER + 1);

  divsqrt_iter_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [REM_W-1:0]      rem_q, rem_nxt, trial;
  logic [RAD_W-1:0]      rad_q;
  logic [NUM_ITER-1:0]   q_q, result_q;
  logic [MANT_WIDTH-1:0] b_q;
  logic                  is_sqrt_q, sticky_q, step_bit;
  logic                  start_acc, last_iter;
  logic [MANT_WIDTH:0]   rad_init;

  assign ready_o   = (state_q != DIVSQRT_BUSY);
  assign done_o    = (state_q == DIVSQRT_DONE);
  assign result_o  = result_q;
  assign sticky_o  = sticky_q;
  assign start_acc = (div_start_i | sqrt_start_i) & ready_o & ~kill_i;
  assign last_iter = (cnt_q == CNT_W'(NUM_ITER - 1));
  assign rad_init  = sqrt_odd_exp_i ? {mant_a_i, 1'b0} : {1'b0, mant_a_i};
  // sqrt trial divisor is {root, 01}; division just compares against b
  assign trial     = is_sqrt_q ? {q_q, 2'b01} : {{(REM_W-MANT_WIDTH){1'b0}}, b_q};

  fpnew_divsqrt_mant_step #(.REM_WIDTH(REM_W)) i_step (
    .rem_i      (rem_q),
    .rad_bits_i (rad_q[RAD_W-1 -: 2]),
    .trial_i    (trial),
    .is_sqrt_i  (is_sqrt_q),
    .rem_o      (rem_nxt),
    .bit_o      (step_bit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= DIVSQRT_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = DIVSQRT_IDLE;
    end else begin
      unique case (state_q)
        DIVSQRT_IDLE: if (start_acc) state_d = DIVSQRT_BUSY;
        DIVSQRT_BUSY: if (last_iter) state_d = DIVSQRT_DONE;
        DIVSQRT_DONE: state_d = start_acc ? DIVSQRT_BUSY : DIVSQRT_IDLE;
        default:      state_d = DIVSQRT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      rad_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      is_sqrt_q <= 1'b0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else if (start_acc) begin
      // division wins when both starts are raised
      is_sqrt_q <= ~div_start_i;
      b_q       <= mant_b_i;
      rem_q     <= div_start_i ? {{(REM_W-MANT_WIDTH){1'b0}}, mant_a_i} : '0;
      rad_q     <= {rad_init, {(RAD_W-MANT_WIDTH-1){1'b0}}};
      q_q       <= '0;
      cnt_q     <= '0;
    end else if (state_q == DIVSQRT_BUSY && !kill_i) begin
      rem_q <= rem_nxt;
      rad_q <= rad_q << 2;
      q_q   <= {q_q[NUM_ITER-2:0], step_bit};
      cnt_q <= cnt_q + CNT_W'(1);
      // outputs only move on completion, so a kill leaves the previous result visible
      if (last_iter) begin
        result_q <= {q_q[NUM_ITER-2:0], step_bit};
        sticky_q <= |rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_mant_iter.sv
// Directed bench for the FP32-sized divsqrt mantissa core: vector table plus handshake corner cases.
module tb_fpnew_divsqrt_mant_iter;

  localparam int MW = 24;
  localparam int NI = MW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          div_start, sqrt_start, kill, odd;
  logic [MW-1:0] a, b;
  logic          ready, done, sticky;
  logic [NI-1:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpnew_divsqrt_mant_iter #(.MANT_WIDTH(MW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .div_start_i    (div_start),
    .sqrt_start_i   (sqrt_start),
    .kill_i         (kill),
    .mant_a_i       (a),
    .mant_b_i       (b),
    .sqrt_odd_exp_i (odd),
    .ready_o        (ready),
    .done_o         (done),
    .result_o       (result),
    .sticky_o       (sticky)
  );

  typedef struct {
    logic          sq;
    logic          odd;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [NI-1:0] res;
    logic          stk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start and count edges until done_o is seen; inputs change #1 after an edge.
  task automatic launch(input logic sq, input logic o, input logic [MW-1:0] aa,
                        input logic [MW-1:0] bb);
    div_start  = ~sq;
    sqrt_start = sq;
    odd        = o;
    a          = aa;
    b          = bb;
    tick();
    div_start  = 1'b0;
    sqrt_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  int lat;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 24'hC00000, 24'h800000, 26'h3000000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 24'h800000, 24'hC00000, 26'h1555555, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 24'h800000, 24'h000000, 26'h2000000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 24'h800000, 24'h000000, 26'h2D413CC, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 24'hC00000, 24'hC00000, 26'h2000000, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 24'h900000, 24'h000000, 26'h3000000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 24'hC80000, 24'h000000, 26'h2800000, 1'b0};

    rst_n = 1'b0; div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
    odd = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_ready",  64'(ready),  64'd1);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].sq, vecs[i].odd, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_ready", i), 64'(ready), 64'd0);
      wait_done(lat);
      // done is first visible after edge T0+NUM_ITER
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(NI));
      check($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
      check($sformatf("v%0d_sticky", i), 64'(sticky), 64'(vecs[i].stk));
      check($sformatf("v%0d_done_ready", i), 64'(ready), 64'd1);
      tick();
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("v%0d_hold", i), 64'(result), 64'(vecs[i].res));
    end

    // kill mid-division with a competing sqrt start in the same cycle
    launch(1'b0, 1'b0, 24'hC00000, 24'h800000);
    repeat (10) tick();
    kill = 1'b1; sqrt_start = 1'b1;
    tick();
    kill = 1'b0; sqrt_start = 1'b0;
    check("kill_ready", 64'(ready), 64'd1);
    begin
      int seen = 0;
      for (int c = 0; c < 60; c++) begin
        if (done) seen++;
        tick();
      end
      check("kill_no_done", 64'(seen), 64'd0);
    end
    check("kill_result_kept", 64'(result), 64'(vecs[7].res));
    check("kill_sticky_kept", 64'(sticky), 64'(vecs[7].stk));

    // back-to-back: sqrt started in the DONE cycle of a division
    launch(1'b0, 1'b0, 24'h800000, 24'hC00000);
    wait_done(lat);
    check("b2b_div_latency", 64'(lat), 64'(NI));
    check("b2b_div_result", 64'(result), 64'h1555555);
    check("b2b_div_sticky", 64'(sticky), 64'd1);
    launch(1'b1, 1'b0, 24'h800000, 24'h000000);
    check("b2b_busy_ready", 64'(ready), 64'd0);
    check("b2b_busy_done", 64'(done), 64'd0);
    check("b2b_result_held", 64'(result), 64'h1555555);
    // starts during BUSY must not disturb the running sqrt
    div_start = 1'b1; a = 24'hC00000; b = 24'h800000; odd = 1'b1;
    tick(); tick(); tick();
    div_start = 1'b0;
    lat = 3;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_sqrt_latency", 64'(lat), 64'(NI));
    check("b2b_sqrt_result", 64'(result), 64'h2000000);
    check("b2b_sqrt_sticky", 64'(sticky), 64'd0);
    tick();
    check("b2b_idle_done", 64'(done), 64'd0);

    // synchronous reset in the middle of an operation
    launch(1'b0, 1'b0, 24'h800000, 24'hC00000);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_ready",  64'(ready),  64'd1);
    check("mrst_done",   64'(done),   64'd0);
    check("mrst_result", 64'(result), 64'd0);
    check("mrst_sticky", 64'(sticky), 64'd0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) seen++;
        tick();
      end
      check("mrst_no_done", 64'(seen), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpnew_divsqrt_mant_iter.md
Name: fpnew_divsqrt_mant_iter

Overview:
Iterative radix-2 mantissa datapath: the responder side of the start/kill/ready/done unit protocol used by the multi-cycle divsqrt wrapper.
- Accepts normalized significands and computes either the quotient a/b or the square root sqrt(a), one result bit per cycle.
- Returns the result bits plus a sticky bit. Exponent, special-case handling and rounding stay in the wrapper.

Parameters:
- MANT_WIDTH, 53, significand width including hidden bit (53=FP64, 24=FP32).
- NUM_ITER, MANT_WIDTH+2 (localparam), number of result bits: integer bit, MANT_WIDTH-1 fraction bits, guard, round.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- div_start_i  in  1  start a division; accepted only while ready_o=1
- sqrt_start_i  in  1  start a square root; accepted only while ready_o=1
- kill_i  in  1  abort the current operation
- mant_a_i  in  MANT_WIDTH  dividend/radicand; MSB must be 1
- mant_b_i  in  MANT_WIDTH  divisor; MSB must be 1; ignored for sqrt
- sqrt_odd_exp_i  in  1  radicand exponent is odd; core uses 2*a
- ready_o  out  1  unit can accept a start this cycle
- done_o  out  1  one-cycle pulse; result valid
- result_o  out  NUM_ITER  result, bit NUM_ITER-1 has weight 2^0
- sticky_o  out  1  final partial remainder is non-zero

Behaviour:
- Reset (rst_ni=0 at a clock edge): state IDLE, ready_o=1, done_o=0, result_o=0, sticky_o=0, iteration counter=0.
- States: IDLE, BUSY, DONE.
- ready_o=1 in IDLE and DONE, 0 in BUSY.
- done_o=1 only in DONE.
- Start is accepted when (div_start_i|sqrt_start_i) & ready_o & ~kill_i.
  - If both starts are high, division wins.
  - Operands, op type and sqrt_odd_exp_i are captured at the accepting edge, then state goes to BUSY with counter=0.
- BUSY: one iteration per cycle. After the NUM_ITER-th iteration, go to DONE.
- Latency: start accepted at edge T0 -> done_o high during the cycle after edge T0+NUM_ITER (NUM_ITER+1 cycles; 56 for FP64).
- DONE: lasts exactly one cycle. Next state is BUSY if a new start is accepted that cycle (back-to-back), otherwise IDLE.
- result_o and sticky_o are valid in DONE and held stable until the next accepted start. Register them; no combinational path from inputs.
- Starts in BUSY are ignored; no error is flagged.
- kill_i=1 at any edge -> next state IDLE, no done_o pulse; any same-cycle start is ignored. result_o keeps its old value.
- Division (restoring), rem width MANT_WIDTH+2:
  - init rem=a.
  - each iteration: t=rem-b. If t>=0 then bit=1, rem=t; else bit=0. Then rem<<=1.
  - Bits are shifted into result_o MSB-first.
  - Quotient lies in (0.5,2): result_o[NUM_ITER-1] may be 0. Normalization is the wrapper's job.
- Square root (restoring, digit-by-digit):
  - radicand = sqrt_odd_exp_i ? {a,1'b0} : {1'b0,a}, zero-extended on the right.
  - each iteration: rem={rem,next 2 radicand bits}; t={root,2'b01}. If rem>=t then rem-=t, root={root,1}; else root={root,0}.
  - rem width NUM_ITER+2.
  - Result lies in [1,2): result_o[NUM_ITER-1]=1.
- sticky_o = |rem after the final iteration.
- mant_b_i with MSB=0 is undefined input; no checking required.

Decomposition:
- Add to fpnew_pkg: typedef enum {DIVSQRT_IDLE, DIVSQRT_BUSY, DIVSQRT_DONE} divsqrt_iter_state_e, and function divsqrt_num_iter(mant_width) returning mant_width+2.
- One combinational sub-module, fpnew_divsqrt_mant_step.
  - Inputs: rem, operand/trial, op.
  - Outputs: next rem, result bit.
  - Keeps the div/sqrt step logic shared and enables a future two-steps-per-cycle variant.

Test Plan:
- MANT_WIDTH=24, div a=0xC00000 (1.5), b=0x800000 -> done_o exactly 27 cycles after the start edge; result_o=0x3000000, sticky_o=0.
- MANT_WIDTH=24, div a=0x800000, b=0xC00000 -> result_o=0x1555555, sticky_o=1.
- MANT_WIDTH=24, sqrt a=0x800000, sqrt_odd_exp_i=0 -> result_o=0x2000000, sticky_o=0. Repeat with sqrt_odd_exp_i=1 -> result_o=0x2D413CC, sticky_o=1.
- Assert kill_i 10 cycles into a div, with sqrt_start_i high in the same cycle -> no done_o for 60 cycles; ready_o=1 on the next cycle; result_o unchanged.
- Start a new sqrt in the DONE cycle of a div -> div result is sampled correctly; ready_o falls next cycle; sqrt done_o arrives 27 cycles after its start. Starts issued during BUSY are ignored.
- rst_ni=0 mid-operation -> after the edge: ready_o=1, done_o=0, result_o=0; no spurious done_o afterwards.
